// File: rtl/mano_seq_ctrl.sv
// mano_seq_ctrl: Mano run flip-flop, sequence counter, timing decoder and interrupt cycle (MANO_INTERRUPT_EN)
module mano_seq_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        hlt,
  input  logic        step,
  input  logic        sc_clr,
  input  logic        ien,
  input  logic        fgi,
  input  logic        fgo,
  output logic        run,
  output logic [3:0]  sc,
  output logic [15:0] t,
  output logic        r,
  output logic        ir_load,
  output logic        ien_clr
);
  logic step_d, step_active, adv, r_clr;
  assign adv = run | step_active;
`ifdef MANO_INTERRUPT_EN
  logic r_set;
  assign r_set = adv & ien & (fgi | fgo) & (sc > 4'd2) & ~r;
  assign r_clr = adv & r & (sc == 4'd2);
  // interrupt-cycle flip-flop: set mid-instruction on a pending flag, cleared when its T2 completes
  always_ff @(posedge clk)
    if (!rst_n) r <= 1'b0;
    else r <= r_set ? 1'b1 : r_clr ? 1'b0 : r;
`else
  logic unused_irq;
  assign unused_irq = ien ^ fgi ^ fgo;
  assign r = 1'b0;
  assign r_clr = 1'b0;
`endif
  // run flip-flop, single-step one-shot and sequence counter
  always_ff @(posedge clk)
    if (!rst_n) begin
      run         <= 1'b0;
      step_d      <= 1'b0;
      step_active <= 1'b0;
      sc          <= 4'd0;
    end else begin
      run         <= hlt ? 1'b0 : start ? 1'b1 : run;
      step_d      <= step;
      step_active <= ~run & step & ~step_d;
      sc          <= (sc_clr | r_clr) ? 4'd0 : adv ? sc + 4'd1 : sc;
    end
  // timing decode and strobes, silent unless advancing
  always_comb begin
    t       = adv ? 16'd1 << sc : 16'd0;
    ir_load = t[1] & ~r;
    ien_clr = r & t[2];
  end
endmodule

// File: tb/tb_mano_seq_ctrl.sv
// tb_mano_seq_ctrl: directed self-checking bench for mano_seq_ctrl
module tb_mano_seq_ctrl;
  logic clk = 1'b0, rst_n, start, hlt, step, sc_clr, ien, fgi, fgo;
  logic run, r, ir_load, ien_clr;
  logic [3:0] sc;
  logic [15:0] t;
  int total = 0, bad = 0;
`ifdef MANO_INTERRUPT_EN
  localparam bit irq = 1'b1;
`else
  localparam bit irq = 1'b0;
`endif
  mano_seq_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .hlt(hlt), .step(step),
    .sc_clr(sc_clr), .ien(ien), .fgi(fgi), .fgo(fgo), .run(run), .sc(sc),
    .t(t), .r(r), .ir_load(ir_load), .ien_clr(ien_clr)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic cyc(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask
  initial begin
    rst_n = 1'b0; start = 1'b1; hlt = 1'b0; step = 1'b0;
    sc_clr = 1'b0; ien = 1'b0; fgi = 1'b0; fgo = 1'b0;
    cyc(2);
    chk("rst_run", run, 0); chk("rst_sc", sc, 0); chk("rst_t", t, 0); chk("rst_r", r, 0);
    rst_n = 1'b1;
    cyc();
    chk("start_run", run, 1); chk("start_t0", t, 16'h0001);
    cyc();
    chk("start_t1", t, 16'h0002); chk("start_irl", ir_load, 1);
    sc_clr = 1'b1;
    cyc();
    sc_clr = 1'b0;
    chk("clr_sc0", sc, 0); chk("clr_t0", t, 16'h0001);
    for (int k = 1; k <= 17; k++) begin
      cyc();
      chk("wrap_sc", sc, k % 16);
      chk("wrap_t", t, 32'(16'd1 << (k % 16)));
      chk("wrap_irl", ir_load, 32'(k % 16 == 1));
    end
    cyc(4);
    chk("sc5", sc, 5);
    sc_clr = 1'b1;
    cyc();
    sc_clr = 1'b0;
    chk("clr5_sc", sc, 0); chk("clr5_t", t, 16'h0001);
    cyc(3);
    chk("sc3", sc, 3);
    hlt = 1'b1; start = 1'b1;
    cyc();
    hlt = 1'b0; start = 1'b0;
    chk("hlt_run", run, 0); chk("hlt_sc", sc, 4); chk("hlt_t", t, 0);
    cyc(2);
    chk("hold_sc", sc, 4); chk("hold_t", t, 0);
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("resume_run", run, 1); chk("resume_t", t, 16'h0010);
    cyc(2);
    hlt = 1'b1;
    cyc();
    hlt = 1'b0;
    chk("stop7_run", run, 0); chk("stop7_sc", sc, 7); chk("stop7_t", t, 0);
    step = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      cyc();
      chk("step_t", t, k == 1 ? 16'h0080 : 16'h0000);
      chk("step_sc", sc, k == 1 ? 7 : 8);
    end
    step = 1'b0;
    cyc();
    chk("step_hold", sc, 8);
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("irq_run", run, 1); chk("irq_t8", t, 16'h0100);
    sc_clr = 1'b1;
    cyc();
    sc_clr = 1'b0;
    cyc(3);
    chk("irq_sc3", sc, 3); chk("irq_r_pre", r, 0);
    ien = 1'b1; fgi = 1'b1;
    cyc();
    ien = 1'b0; fgi = 1'b0;
    chk("irq_set_r", r, irq); chk("irq_sc4", sc, 4);
    sc_clr = 1'b1;
    cyc();
    sc_clr = 1'b0;
    chk("irq_c0_sc", sc, 0); chk("irq_c0_r", r, irq); chk("irq_c0_ienclr", ien_clr, 0);
    cyc();
    chk("irq_c1_sc", sc, 1); chk("irq_c1_irl", ir_load, !irq); chk("irq_c1_r", r, irq);
    cyc();
    chk("irq_c2_sc", sc, 2); chk("irq_c2_ienclr", ien_clr, irq); chk("irq_c2_t", t, 16'h0004);
    cyc();
    chk("irq_end_r", r, 0); chk("irq_end_sc", sc, irq ? 0 : 3);
    cyc(2);
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    chk("midrst_run", run, 0); chk("midrst_sc", sc, 0); chk("midrst_t", t, 0); chk("midrst_r", r, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
